spike_window_counter: RTL and testbench
=======================================

Name: spike_window_counter

Overview:
- Consumes the delayed spike stream read out of the block-RAM spike delay line (one bit per clk1 cycle).
- Counts spikes over a programmable window of clk1 cycles and presents each window's count to the next stage through a valid/ready handshake.
- The next stage is the rate logger or host pipe; this block sits directly downstream of the delay line's doutb.

Parameters:
- WIN_W, 19, width of window length and window cycle counter (matches delay-line address width).
- CNT_W, 16, width of the spike count result.

Ports:
- clk1  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk1 rising edge.
- enable  in  1  run counting when high; low aborts the current window.
- win_len  in  WIN_W  window length in clk1 cycles; sampled at window start; 0 is treated as 1.
- spike_in  in  1  delayed spike bit from the delay line.
- out_ready  in  1  downstream accepts the result when high together with rate_valid.
- rate_cnt  out  CNT_W  spike count of the last completed window.
- rate_valid  out  1  rate_cnt holds an unconsumed result.
- rate_sat  out  1  the result in rate_cnt saturated.
- overrun  out  1  sticky flag: a completed window was dropped because the output was still occupied.

Behaviour:
- Reset (reset==0 at a clk1 edge):
  - state=IDLE.
  - Window counter, spike accumulator, latched length, and edge register all 0.
  - rate_cnt=0, rate_valid=0, rate_sat=0, overrun=0.
- States:
  - IDLE: if enable==1, latch win_len_q=max(win_len,1), clear the accumulator and window counter, go to COUNT. The spike in this cycle is not counted.
  - COUNT: each cycle, win_cnt increments and the accumulator adds hit (see Optional Feature).
  - Accumulator saturates at 2^CNT_W-1; sat_acc is set once saturated.
  - When win_cnt==win_len_q-1 (the last cycle), the final value is acc+hit (saturating). On the next edge that value is the result.
  - On that same edge: win_cnt=0, acc=0, sat_acc=0, win_len_q re-latched from win_len. There is no dead cycle between windows.
  - enable==0 in COUNT: discard the partial window and go to IDLE. A pending output result is unaffected.
- Output register:
  - A completed result is loaded when rate_valid==0, or when rate_valid&&out_ready in the same cycle (simultaneous consume and load). The load sets rate_cnt, rate_sat, and rate_valid=1.
  - Latency: the result is visible the cycle after the window's last cycle.
  - Result completes while rate_valid==1 and out_ready==0: the new result is dropped, the old result is held, and overrun is set. overrun clears only on reset.
  - rate_valid&&out_ready with no new result: rate_valid goes to 0 next cycle; rate_cnt holds its value.
  - rate_cnt, rate_sat, and rate_valid must not change while rate_valid==1 and out_ready==0.
- Width rules: win_cnt is WIN_W bits and never exceeds win_len_q-1. The accumulator is CNT_W bits with explicit saturation, never wrapping.
- win_len==1: every cycle in COUNT completes a window; the result equals hit of that cycle.

Optional Feature:
- Macro: SPIKE_EDGE_DETECT_EN.
- Defined: hit = spike_in & ~spike_q, where spike_q is spike_in registered and reset to 0. A spike held high for N cycles counts once. spike_q keeps updating in IDLE, so a spike already high at window start is not counted.
- Undefined: hit = spike_in (level count), one count per high cycle, and no spike_q register exists.

Decomposition:
- Package spike_window_pkg holds:
  - the state enum (IDLE, COUNT);
  - the default widths WIN_W_DEF=19 and CNT_W_DEF=16;
  - the constant CNT_MAX as a function of CNT_W.
- Natural sub-module: spike_hit_gen, containing the edge/level selection under SPIKE_EDGE_DETECT_EN. Its ports are clk1, reset, spike_in, and hit.

Test Plan:
- Reset and idle: reset=0 for 5 cycles, then enable=0 with spikes present -> all outputs 0 and rate_valid never rises.
- Basic window: win_len=10, enable=1, out_ready=1, spike_in high for one cycle at window cycles 2, 5, and 9 -> rate_cnt=3, rate_valid=1 for one cycle, 1 cycle after cycle 9. The next window starts with no gap.
- Backpressure/overrun: win_len=4, out_ready=0 for 12 cycles, 1 spike per window -> first result held at rate_cnt=1 and overrun=1 after the second window. Set out_ready=1 -> the held result is consumed and later windows flow normally.
- Saturation: CNT_W=4, win_len=40, spike_in held high (feature undefined) -> rate_cnt=15, rate_sat=1. With SPIKE_EDGE_DETECT_EN defined -> rate_cnt=0 (the spike was already high at start), rate_sat=0.
- Abort and reset mid-window: win_len=20, 3 spikes, enable=0 at cycle 8 -> no result and state returns to IDLE. Separately, reset=0 at cycle 8 -> all outputs 0 on the next edge.
- win_len=0: spike_in = 1,0,1 -> three consecutive results 1,0,1 with out_ready=1.

Source files
------------

// File: rtl/spike_window_pkg.sv
// ----------------------------------------------------------------------------
// spike_window_pkg
// Shared types and constants for the spike window counter.
//   state_t    : window FSM states (IDLE, COUNT)
//   WIN_W_DEF  : default window length / window counter width
//   CNT_W_DEF  : default spike count width
//   cnt_max()  : saturation ceiling (2^cnt_w - 1) for a given count width
// ----------------------------------------------------------------------------
package spike_window_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int WIN_W_DEF = 19;
    localparam int CNT_W_DEF = 16;

    // Computed in 64 bits so that cnt_w == 32 still yields all ones.
    function automatic logic [63:0] cnt_max(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/spike_hit_gen.sv
// ----------------------------------------------------------------------------
// spike_hit_gen
// Turns the delayed spike bit into the per-cycle "hit" that the window
// accumulator adds.
//   Macro SPIKE_EDGE_DETECT_EN defined   : hit = rising edge of spike_in, so a
//                                          spike held high for N cycles counts
//                                          once. The history register keeps
//                                          updating regardless of window state.
//   Macro SPIKE_EDGE_DETECT_EN undefined : hit = spike_in (level count); no
//                                          history register exists.
// Ports:
//   clk1     in  system clock, rising edge
//   reset    in  synchronous active-low reset
//   spike_in in  delayed spike bit from the delay line
//   hit      out spike event for the current cycle
// ----------------------------------------------------------------------------
module spike_hit_gen (
    input  logic clk1,
    input  logic reset,
    input  logic spike_in,
    output logic hit
);

`ifdef SPIKE_EDGE_DETECT_EN
    logic r_spike_q;

    always_ff @(posedge clk1) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order.
        if (!reset) begin
            r_spike_q <= 1'b0;
        end else begin
            r_spike_q <= spike_in;
        end
    end

    assign hit = spike_in & ~r_spike_q;
`else
    // Clock and reset have no load in the level-count build.
    logic w_unused;
    assign w_unused = &{1'b0, clk1, reset};

    assign hit = spike_in;
`endif

endmodule

// File: rtl/spike_window_counter.sv
// ----------------------------------------------------------------------------
// spike_window_counter
// Counts spikes from the delay-line read port over a programmable window of
// clk1 cycles and offers each window's count downstream via valid/ready.
// Windows run back to back with no dead cycle; a result that completes while
// the output still holds an unconsumed one is dropped and flagged in the
// sticky overrun bit.
//
// Optional feature macro: SPIKE_EDGE_DETECT_EN (see spike_hit_gen) selects
// rising-edge counting instead of level counting.
//
// Parameters:
//   WIN_W  width of win_len and the window cycle counter
//   CNT_W  width of the spike count result
// Ports:
//   clk1        in  system clock, rising edge
//   reset       in  synchronous active-low reset
//   enable      in  run counting; low aborts the current window
//   win_len     in  window length in cycles, sampled at window start (0 -> 1)
//   spike_in    in  delayed spike bit
//   out_ready   in  downstream accepts the result with rate_valid
//   rate_cnt    out spike count of the last completed window
//   rate_valid  out rate_cnt holds an unconsumed result
//   rate_sat    out the result in rate_cnt saturated
//   overrun     out sticky: a completed window was dropped
// ----------------------------------------------------------------------------
module spike_window_counter
    import spike_window_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic             spike_in,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rate_cnt,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    state_t           r_state;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] r_win_len_q;
    logic [CNT_W-1:0] r_acc;
    logic             r_sat_acc;
    logic [CNT_W-1:0] r_rate_cnt;
    logic             r_rate_valid;
    logic             r_rate_sat;
    logic             r_overrun;

    logic             w_hit;
    logic [WIN_W-1:0] w_len_eff;
    logic             w_last;
    logic             w_done;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_sat_next;

    spike_hit_gen u_hit_gen (
        .clk1     (clk1),
        .reset    (reset),
        .spike_in (spike_in),
        .hit      (w_hit)
    );

    assign w_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_last    = (r_win_cnt == r_win_len_q - WIN_W'(1));
    // A window only completes if enable is still high on its last cycle;
    // dropping enable on that cycle discards it like any other abort.
    assign w_done    = (r_state == COUNT) && enable && w_last;

    always_comb begin
        // NOTE: default assignment first so no path leaves w_acc_next
        // unassigned, which would infer a latch.
        w_acc_next = r_acc;
        if (w_hit && (r_acc != CNT_MAX)) begin
            w_acc_next = r_acc + CNT_W'(1);
        end
    end

    // The accumulator never decreases inside a window, so reaching the
    // ceiling marks the window as saturated for the rest of its life.
    assign w_sat_next = r_sat_acc | (w_acc_next == CNT_MAX);

    always_ff @(posedge clk1) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_win_cnt    <= '0;
            r_win_len_q  <= '0;
            r_acc        <= '0;
            r_sat_acc    <= 1'b0;
            r_rate_cnt   <= '0;
            r_rate_valid <= 1'b0;
            r_rate_sat   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Window FSM
            case (r_state)
                IDLE: begin
                    // The spike of the start cycle is deliberately not counted.
                    if (enable) begin
                        r_win_len_q <= w_len_eff;
                        r_win_cnt   <= '0;
                        r_acc       <= '0;
                        r_sat_acc   <= 1'b0;
                        r_state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        // Next window starts on this same edge.
                        r_win_cnt   <= '0;
                        r_acc       <= '0;
                        r_sat_acc   <= 1'b0;
                        r_win_len_q <= w_len_eff;
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_acc     <= w_acc_next;
                        r_sat_acc <= w_sat_next;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Output register: a slot is free when empty or being consumed now.
            if (w_done) begin
                if (!r_rate_valid || out_ready) begin
                    r_rate_cnt   <= w_acc_next;
                    r_rate_sat   <= w_sat_next;
                    r_rate_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rate_valid && out_ready) begin
                r_rate_valid <= 1'b0;
            end
        end
    end

    assign rate_cnt   = r_rate_cnt;
    assign rate_valid = r_rate_valid;
    assign rate_sat   = r_rate_sat;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_window_counter.sv
module tb_spike_window_counter;

    localparam int WIN_W   = 19;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk1 = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             spike_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] rate_cnt;
    logic             rate_valid;
    logic             rate_sat;
    logic             overrun;

    int n_total = 0;
    int n_bad   = 0;

    spike_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .enable     (enable),
        .win_len    (win_len),
        .spike_in   (spike_in),
        .out_ready  (out_ready),
        .rate_cnt   (rate_cnt),
        .rate_valid (rate_valid),
        .rate_sat   (rate_sat),
        .overrun    (overrun)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (window-level bookkeeping) ----------
    bit m_active;
    int m_pos;
    int m_len;
    int m_hits;
    bit m_prev;
    int m_cnt;
    bit m_valid;
    bit m_sat;
    bit m_ovr;

    task automatic model_step();
        bit hit;
        bit done;
        int res;
        bit rsat;
        done = 1'b0;
        res  = 0;
        rsat = 1'b0;
        if (!reset) begin
            m_active = 0; m_pos = 0; m_len = 0; m_hits = 0; m_prev = 0;
            m_cnt = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
        end else begin
`ifdef SPIKE_EDGE_DETECT_EN
            hit = spike_in && !m_prev;
`else
            hit = spike_in;
`endif
            if (!m_active) begin
                if (enable) begin
                    m_active = 1;
                    m_pos    = 0;
                    m_hits   = 0;
                    m_len    = (win_len == 0) ? 1 : int'(win_len);
                end
            end else if (!enable) begin
                m_active = 0;
            end else begin
                m_hits += int'(hit);
                if (m_pos == m_len - 1) begin
                    done   = 1;
                    res    = (m_hits > CNT_MAX) ? CNT_MAX : m_hits;
                    rsat   = (m_hits >= CNT_MAX);
                    m_pos  = 0;
                    m_hits = 0;
                    m_len  = (win_len == 0) ? 1 : int'(win_len);
                end else begin
                    m_pos++;
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_cnt = res; m_sat = rsat; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            m_prev = spike_in;
        end
    endtask

    // ---------------- helpers ---------------------------------------------
    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic apply(input logic rst_v, input logic en_v, input int wl_v,
                         input logic sp_v, input logic rdy_v);
        reset     = rst_v;
        enable    = en_v;
        win_len   = WIN_W'(wl_v);
        spike_in  = sp_v;
        out_ready = rdy_v;
        @(posedge clk1);
        #1;
        model_step();
        check("model.rate_cnt",   rate_cnt,   m_cnt);
        check("model.rate_valid", rate_valid, m_valid);
        check("model.rate_sat",   rate_sat,   m_sat);
        check("model.overrun",    overrun,    m_ovr);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 7, 1'(i % 2), 1'b0);
        check("reset.rate_cnt",   rate_cnt,   0);
        check("reset.rate_valid", rate_valid, 0);
        check("reset.rate_sat",   rate_sat,   0);
        check("reset.overrun",    overrun,    0);
    endtask

    typedef struct {
        logic rst;
        logic en;
        int   wl;
        logic sp;
        logic rdy;
        logic e_valid;
        int   e_cnt;
        logic e_sat;
        logic e_ovr;
    } vec_t;

    function automatic vec_t mk(input logic en, input int wl, input logic sp,
                                input logic rdy, input logic ev, input int ec,
                                input logic eo);
        vec_t v;
        v.rst = 1'b1; v.en = en; v.wl = wl; v.sp = sp; v.rdy = rdy;
        v.e_valid = ev; v.e_cnt = ec; v.e_sat = 1'b0; v.e_ovr = eo;
        return v;
    endfunction

    // ---------------- test sequence ---------------------------------------
    initial begin
        vec_t tbl[$];
        bit   seen;
        int   dens;

        // Reset, then idle with spikes present: nothing may appear.
        do_reset();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 5, 1'($urandom_range(0, 1)), 1'b1);
            if (rate_valid) seen = 1;
        end
        check("idle.valid_never", seen, 0);
        check("idle.rate_cnt", rate_cnt, 0);

        // Table: win_len=0 back-to-back results, then backpressure/overrun.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 4, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 4, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 4, 0, 1, 1, 2, 1));
        tbl.push_back(mk(0, 4, 0, 1, 0, 2, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].wl, tbl[i].sp, tbl[i].rdy);
            check($sformatf("tbl[%0d].rate_valid", i), rate_valid, tbl[i].e_valid);
            check($sformatf("tbl[%0d].rate_cnt", i),   rate_cnt,   tbl[i].e_cnt);
            check($sformatf("tbl[%0d].rate_sat", i),   rate_sat,   tbl[i].e_sat);
            check($sformatf("tbl[%0d].overrun", i),    overrun,    tbl[i].e_ovr);
        end

        // Basic window: win_len=10, spikes at 2,5,9; start-cycle spike ignored.
        do_reset();
        apply(1'b1, 1'b1, 10, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 10, 1'(i == 2 || i == 5 || i == 9), 1'b1);
            if (i < 9) check("basic.valid_early", rate_valid, 0);
        end
        check("basic.valid", rate_valid, 1);
        check("basic.cnt",   rate_cnt,   3);
        // Next window follows with no gap: spikes at 1 and 9.
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 10, 1'(i == 1 || i == 9), 1'b1);
            if (i == 0) check("basic.valid_drop", rate_valid, 0);
        end
        check("basic2.valid", rate_valid, 1);
        check("basic2.cnt",   rate_cnt,   2);

        // Saturation: spike held high across a 40-cycle window.
        do_reset();
        apply(1'b1, 1'b1, 40, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) apply(1'b1, 1'b1, 40, 1'b1, 1'b1);
        check("sat.valid", rate_valid, 1);
`ifdef SPIKE_EDGE_DETECT_EN
        check("sat.cnt", rate_cnt, 0);
        check("sat.sat", rate_sat, 0);
`else
        check("sat.cnt", rate_cnt, 15);
        check("sat.sat", rate_sat, 1);
`endif

        // Abort mid-window: no result, then a fresh window starts from IDLE.
        do_reset();
        apply(1'b1, 1'b1, 20, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 20, 1'(i == 1 || i == 3 || i == 5), 1'b1);
        apply(1'b1, 1'b0, 20, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            apply(1'b1, 1'b0, 20, 1'($urandom_range(0, 1)), 1'b1);
            if (rate_valid) seen = 1;
        end
        check("abort.no_result", seen, 0);
        apply(1'b1, 1'b1, 3, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 3, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 3, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 3, 1'b1, 1'b1);
        check("abort.restart_valid", rate_valid, 1);
        check("abort.restart_cnt",   rate_cnt,   2);

        // Reset mid-window with a pending result.
        do_reset();
        apply(1'b1, 1'b1, 3, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 3, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 3, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 20, 1'b1, 1'b0);
        check("rstmid.pending_valid", rate_valid, 1);
        check("rstmid.pending_cnt",   rate_cnt,   2);
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 20, 1'(i % 2), 1'b0);
        apply(1'b0, 1'b1, 20, 1'b1, 1'b0);
        check("rstmid.valid", rate_valid, 0);
        check("rstmid.cnt",   rate_cnt,   0);
        check("rstmid.sat",   rate_sat,   0);
        check("rstmid.ovr",   overrun,    0);

        // Randomised run against the model.
        do_reset();
        dens = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(1, 9);
            apply(1'($urandom_range(0, 499) != 0),
                  1'($urandom_range(0, 19) != 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 5)),
                  1'($urandom_range(0, 9) < dens),
                  1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
